// File: rtl/parallel_to_serial_tx_pkg.sv
// Shared definitions for the MSB-first serial word link (transmit and receive sides).
// State encodings must stay identical to the receiver's.
package parallel_to_serial_tx_pkg;

  localparam int WORD_W = 8;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/parallel_to_serial_tx.sv
// Serial word transmitter: one-deep holding register feeding an MSB-first shifter,
// with a start strobe on the first bit and a done strobe on the last bit.
module parallel_to_serial_tx
  import parallel_to_serial_tx_pkg::*;
#(
  parameter int N = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         ready,
  output logic         q,
  output logic         start,
  output logic         done,
  output logic         done_dly,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Handshake: a word transfers on a rising edge where load && ready.
  // ready is high exactly when the holding register is empty.

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     shreg, shreg_n;
  logic [N-1:0]     hold, hold_n;
  logic             hold_valid, hold_valid_n;
  logic             q_n, start_n, done_n;
  logic             free, accept;

  assign ready = !hold_valid;
  assign busy  = (state == STATE_SHIFT) || hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STATE_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      q          <= 1'b0;
      start      <= 1'b0;
      done       <= 1'b0;
      done_dly   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      q          <= q_n;
      start      <= start_n;
      done       <= done_n;
      done_dly   <= done;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    accept       = load && ready;
    free         = (state == STATE_IDLE) || ((state == STATE_SHIFT) && (cnt == LAST));

    if (free) begin
      // A held word always wins; a fresh load can only arrive when hold is empty.
      if (hold_valid) begin
        shreg_n      = hold;
        hold_valid_n = 1'b0;
        state_n      = STATE_SHIFT;
        cnt_n        = '0;
      end else if (accept) begin
        shreg_n = data_in;
        state_n = STATE_SHIFT;
        cnt_n   = '0;
      end else begin
        state_n = STATE_IDLE;
        cnt_n   = '0;
      end
    end else begin
      shreg_n = shreg << 1;
      cnt_n   = cnt + 1'b1;
      if (accept) begin
        hold_n       = data_in;
        hold_valid_n = 1'b1;
      end
    end

    // Outputs are registered from the next-state view so they line up with state.
    q_n     = (state_n == STATE_SHIFT) ? shreg_n[N-1] : 1'b0;
    start_n = (state_n == STATE_SHIFT) && (cnt_n == '0);
    done_n  = (state_n == STATE_SHIFT) && (cnt_n == LAST);
  end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Bench for parallel_to_serial_tx: directed scenarios plus random traffic against a
// frame-schedule reference model and a loopback receiver scoreboard.
module tb_parallel_to_serial_tx;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load;
  logic       ready, q, start, done, done_dly, busy;

  logic [4:0] data5;
  logic       load5;
  logic       ready5, q5, start5, done5, done_dly5, busy5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial_tx #(.N(8)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready),
    .q(q), .start(start), .done(done), .done_dly(done_dly), .busy(busy)
  );

  parallel_to_serial_tx #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .data_in(data5), .load(load5), .ready(ready5),
    .q(q5), .start(start5), .done(done5), .done_dly(done_dly5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted word is a frame scheduled at cycle
  // s = max(accept_cycle, previous_s + N); it sits in hold from accept_cycle to s-1.
  int         fr_k[$];
  int         fr_s[$];
  logic [7:0] fr_w[$];
  int         last_s;
  int         cyc;
  logic       prev_exp_done;
  logic [7:0] exp_q[$];

  task automatic model_at(input int c, output logic eq, output logic es, output logic ed,
                          output logic eb, output logic er);
    logic [7:0] w;
    eq = 1'b0; es = 1'b0; ed = 1'b0; eb = 1'b0; er = 1'b1;
    foreach (fr_s[i]) begin
      if (c >= fr_s[i] && c <= fr_s[i] + N - 1) begin
        w  = fr_w[i];
        eq = w[N - 1 - (c - fr_s[i])];
        es = (c == fr_s[i]);
        ed = (c == fr_s[i] + N - 1);
        eb = 1'b1;
      end
      if (c >= fr_k[i] && c <= fr_s[i] - 1) begin
        er = 1'b0;
        eb = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    fr_k.delete(); fr_s.delete(); fr_w.delete(); exp_q.delete();
    last_s = -1000;
    prev_exp_done = 1'b0;
  endtask

  task automatic check_outputs(input int c);
    logic eq, es, ed, eb, er;
    model_at(c, eq, es, ed, eb, er);
    check("q", q, eq);
    check("start", start, es);
    check("done", done, ed);
    check("busy", busy, eb);
    check("ready", ready, er);
    check("done_dly", done_dly, prev_exp_done);
    prev_exp_done = ed;
  endtask

  // Present inputs for the current cycle, take one edge, check the new cycle.
  task automatic step(input logic ld, input logic [7:0] d);
    logic eq, es, ed, eb, er, acc;
    int   s;
    load    = ld;
    data_in = d;
    model_at(cyc, eq, es, ed, eb, er);
    acc = ld && er;
    @(posedge clk);
    cyc++;
    if (acc) begin
      s = (cyc > last_s + N) ? cyc : last_s + N;
      fr_k.push_back(cyc); fr_s.push_back(s); fr_w.push_back(d);
      exp_q.push_back(d);
      last_s = s;
    end
    #1;
    check_outputs(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)));
  endtask

  // Loopback receiver: shifts q in every cycle and captures the word on the done edge.
  logic [7:0] rx_sh;
  always @(posedge clk) begin
    if (rst) begin
      rx_sh = '0;
    end else begin
      rx_sh = {rx_sh[6:0], q};
      if (done) begin
        if (exp_q.size() == 0) check("loopback_extra", rx_sh, 32'hFFFF_FFFF);
        else check("loopback", rx_sh, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    rst = 1'b1; load = 1'b0; data_in = '0; load5 = 1'b0; data5 = '0;
    model_clear();
    cyc = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_q", q, 0); check("rst_start", start, 0); check("rst_done", done, 0);
    check("rst_done_dly", done_dly, 0); check("rst_busy", busy, 0); check("rst_ready", ready, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); cyc++; #1; check_outputs(cyc);

    // Single word, then back-to-back, overflow, last-bit load
    step(1'b1, 8'hA5); idle(12);
    step(1'b1, 8'h3C); step(1'b1, 8'hC3); idle(20);
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'hFF); idle(20);
    step(1'b1, 8'h00); idle(7); step(1'b1, 8'h81); idle(12);
    check("drain_directed", exp_q.size(), 0);

    // Asynchronous reset mid-frame with a word held
    step(1'b1, 8'hF0); step(1'b1, 8'h5A); idle(2);
    #2 rst = 1'b1;
    #1;
    check("arst_q", q, 0); check("arst_start", start, 0); check("arst_busy", busy, 0);
    check("arst_ready", ready, 1); check("arst_done", done, 0);
    model_clear();
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); cyc++; #1; check_outputs(cyc);
    idle(12);

    // Random traffic with data_in churning every cycle
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 9) < 4, 8'($urandom_range(0, 255)));
    idle(24);
    check("drain_random", exp_q.size(), 0);

    // N=5 instance
    pat = 5'b10110;
    load5 = 1'b1; data5 = pat;
    @(posedge clk); #1;
    load5 = 1'b0; data5 = 5'b01001;
    for (int i = 0; i < 5; i++) begin
      check("n5_q", q5, pat[4 - i]);
      check("n5_start", start5, i == 0);
      check("n5_done", done5, i == 4);
      check("n5_cnt_max", u_dut5.cnt <= 3'd4, 1);
      @(posedge clk); #1;
    end
    check("n5_done_dly", done_dly5, 1);
    check("n5_idle_q", q5, 0);
    check("n5_idle_busy", busy5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
